// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT output path.
// A beat is LANES consecutive samples, so each sample index is {beat index, lane}.
package fft_pkg;

  localparam int N_FFT    = 512;
  localparam int LANES    = 16;
  localparam int SAMPLE_W = 13;
  localparam int BLK_W    = 5;
  localparam int LANE_W   = 4;
  localparam int IDX_W    = BLK_W + LANE_W;
  localparam int DROP_W   = 8;
  localparam int N_BLK    = N_FFT / LANES;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {IDLE, STREAM} stream_state_t;

endpackage

// File: rtl/fft_out_streamer.sv
// Captures one reordered FFT frame and streams it downstream as N_BLK beats of
// LANES samples over a ready/valid handshake, counting frames that arrive while busy.
module fft_out_streamer
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_valid,
  input  sample_t             frame_i [N_FFT],
  input  sample_t             frame_q [N_FFT],
  output logic                frame_ready,
  output logic                dout_valid,
  input  logic                dout_ready,
  output sample_t             dout_i [LANES],
  output sample_t             dout_q [LANES],
  output logic [BLK_W-1:0]    dout_blk,
  output logic                dout_last,
  output logic [DROP_W-1:0]   drop_cnt
);

  stream_state_t     state_q;
  logic [BLK_W-1:0]  blk_q;
  logic [DROP_W-1:0] drop_cnt_q;
  sample_t           buf_i_q [N_FFT];
  sample_t           buf_q_q [N_FFT];

  logic streaming;
  logic last_beat;
  logic beat_xfer;
  logic frame_accept;

  assign streaming    = (state_q == STREAM);
  assign last_beat    = streaming && (blk_q == BLK_W'(N_BLK - 1));
  assign beat_xfer    = streaming && dout_ready;
  // A new frame can land on the same edge the final beat leaves, giving zero bubble.
  assign frame_ready  = !rst && ((state_q == IDLE) || (beat_xfer && last_beat));
  assign frame_accept = frame_valid && frame_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (frame_accept) begin
        state_q <= STREAM;
        blk_q   <= '0;
      end else if (beat_xfer) begin
        if (last_beat) begin
          state_q <= IDLE;
          blk_q   <= '0;
        end else begin
          blk_q <= blk_q + BLK_W'(1);
        end
      end
      if (frame_valid && !frame_ready && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + DROP_W'(1);
      end
    end
  end

  // Frame store has no reset: it is only observable while streaming, after a capture.
  always_ff @(posedge clk) begin
    if (frame_accept) begin
      for (int n = 0; n < N_FFT; n++) begin
        buf_i_q[n] <= frame_i[n];
        buf_q_q[n] <= frame_q[n];
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [LANE_W-1:0] LaneIdx = LANE_W'(gi);
    assign dout_i[gi] = streaming ? buf_i_q[{blk_q, LaneIdx}] : '0;
    assign dout_q[gi] = streaming ? buf_q_q[{blk_q, LaneIdx}] : '0;
  end

  assign dout_valid = streaming;
  assign dout_blk   = streaming ? blk_q : '0;
  assign dout_last  = last_beat;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_fft_out_streamer.sv
// Directed bench for fft_out_streamer: streaming order, backpressure, back-to-back
// frames, drop counting/saturation, mid-stream reset and extreme sample values.
module tb_fft_out_streamer;
  import fft_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_valid;
  sample_t           frame_i [N_FFT];
  sample_t           frame_q [N_FFT];
  logic              frame_ready;
  logic              dout_valid;
  logic              dout_ready;
  sample_t           dout_i [LANES];
  sample_t           dout_q [LANES];
  logic [BLK_W-1:0]  dout_blk;
  logic              dout_last;
  logic [DROP_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_out_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame_i     (frame_i),
    .frame_q     (frame_q),
    .frame_ready (frame_ready),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_i      (dout_i),
    .dout_q      (dout_q),
    .dout_blk    (dout_blk),
    .dout_last   (dout_last),
    .drop_cnt    (drop_cnt)
  );

  // Present the current frame_i/frame_q for one edge; returns at beat 0's cycle.
  task automatic load_frame();
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    frame_valid = 1'b0;
    dout_ready  = 1'b0;
    for (int n = 0; n < N_FFT; n++) begin
      frame_i[n] = '0;
      frame_q[n] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (frame_ready !== 1'b0 || dout_valid !== 1'b0 || drop_cnt !== 8'd0 ||
        dout_blk !== 5'd0 || dout_last !== 1'b0 || dout_i[0] !== 13'sd0 || dout_q[15] !== 13'sd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b drop=%0d blk=%0d last=%b i0=%0d q15=%0d, expected all 0",
               frame_ready, dout_valid, drop_cnt, dout_blk, dout_last, dout_i[0], dout_q[15]);
    end else $display("reset_state ok");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", frame_ready);
    end else $display("reset_release_ready ok");
    @(negedge clk);
  endtask

  task automatic test_single();
    bit bad;
    for (int n = 0; n < N_FFT; n++) begin
      frame_i[n] = sample_t'(n);
      frame_q[n] = sample_t'(-n);
    end
    dout_ready = 1'b1;
    load_frame();
    for (int b = 0; b < N_BLK; b++) begin
      #1;
      bad = 1'b0;
      for (int k = 0; k < LANES; k++)
        if (dout_i[k] !== sample_t'(16*b+k) || dout_q[k] !== sample_t'(-(16*b+k))) bad = 1'b1;
      checks++;
      if (dout_valid !== 1'b1 || bad || dout_blk !== BLK_W'(b) || dout_last !== (b == 31 ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL single_beat %0d: valid=%b blk=%0d last=%b i0=%0d q0=%0d, expected valid=1 blk=%0d last=%b i0=%0d q0=%0d",
                 b, dout_valid, dout_blk, dout_last, dout_i[0], dout_q[0], b, (b == 31), 16*b, -16*b);
      end else $display("single_beat %0d ok", b);
      @(negedge clk);
    end
    #1;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_end_valid: got %b expected 0", dout_valid);
    end else $display("single_end_valid ok");
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit bad;
    int eb = 0;
    int c  = 0;
    for (int n = 0; n < N_FFT; n++) begin
      frame_i[n] = sample_t'(2*n - 500);
      frame_q[n] = sample_t'(n + 7);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    load_frame();
    while (eb < N_BLK && c < 200) begin
      dout_ready = pat[c % 4];
      #1;
      bad = 1'b0;
      for (int k = 0; k < LANES; k++)
        if (dout_i[k] !== sample_t'(2*(16*eb+k) - 500) || dout_q[k] !== sample_t'(16*eb+k+7)) bad = 1'b1;
      checks++;
      if (dout_valid !== 1'b1 || bad || dout_blk !== BLK_W'(eb) ||
          frame_ready !== ((dout_ready && eb == 31) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL bp_cycle %0d: valid=%b blk=%0d ready_up=%b i0=%0d, expected valid=1 blk=%0d i0=%0d",
                 c, dout_valid, dout_blk, frame_ready, dout_i[0], eb, 32*eb - 500);
      end else $display("bp_cycle %0d beat %0d ready=%b ok", c, eb, dout_ready);
      @(negedge clk);
      if (dout_ready) eb++;
      c++;
    end
    #1;
    checks++;
    if (eb != N_BLK || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: beats=%0d valid=%b, expected beats=32 valid=0", eb, dout_valid);
    end else $display("bp_end ok");
  endtask

  task automatic test_back_to_back();
    bit bad;
    for (int n = 0; n < N_FFT; n++) begin
      frame_i[n] = sample_t'(100);
      frame_q[n] = '0;
    end
    dout_ready = 1'b1;
    load_frame();
    for (int b = 0; b < N_BLK; b++) begin
      if (b == 31) begin
        for (int n = 0; n < N_FFT; n++) begin
          frame_i[n] = sample_t'(-200);
          frame_q[n] = sample_t'(n);
        end
        frame_valid = 1'b1;
      end
      #1;
      checks++;
      if (dout_valid !== 1'b1 || dout_blk !== BLK_W'(b) || dout_i[3] !== 13'sd100 ||
          (b == 31 && frame_ready !== 1'b1)) begin
        errors++;
        $display("FAIL b2b_a beat %0d: valid=%b blk=%0d i3=%0d ready_up=%b, expected valid=1 blk=%0d i3=100",
                 b, dout_valid, dout_blk, dout_i[3], frame_ready, b);
      end else $display("b2b_a beat %0d ok", b);
      @(negedge clk);
    end
    frame_valid = 1'b0;
    for (int b = 0; b < N_BLK; b++) begin
      for (int n = 0; n < N_FFT; n++) frame_i[n] = sample_t'(123 + b);
      #1;
      bad = 1'b0;
      for (int k = 0; k < LANES; k++)
        if (dout_i[k] !== sample_t'(-200) || dout_q[k] !== sample_t'(16*b+k)) bad = 1'b1;
      checks++;
      if (dout_valid !== 1'b1 || bad || dout_blk !== BLK_W'(b)) begin
        errors++;
        $display("FAIL b2b_b beat %0d: valid=%b blk=%0d i0=%0d q0=%0d, expected valid=1 blk=%0d i0=-200 q0=%0d",
                 b, dout_valid, dout_blk, dout_i[0], dout_q[0], b, 16*b);
      end else $display("b2b_b beat %0d ok", b);
      @(negedge clk);
    end
    #1;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end_valid: got %b expected 0", dout_valid);
    end else $display("b2b_end_valid ok");
  endtask

  task automatic test_drop();
    bit bad;
    for (int n = 0; n < N_FFT; n++) begin
      frame_i[n] = sample_t'(n);
      frame_q[n] = sample_t'(-n);
    end
    dout_ready = 1'b1;
    load_frame();
    for (int b = 0; b < N_BLK; b++) begin
      if (b == 10) begin
        for (int n = 0; n < N_FFT; n++) frame_i[n] = sample_t'(777);
        frame_valid = 1'b1;
      end
      #1;
      if (b == 10) begin
        checks++;
        if (frame_ready !== 1'b0) begin
          errors++;
          $display("FAIL drop_ready_low: got %b expected 0", frame_ready);
        end else $display("drop_ready_low ok");
      end
      if (b == 11) begin
        checks++;
        if (drop_cnt !== 8'd1) begin
          errors++;
          $display("FAIL drop_cnt_one: got %0d expected 1", drop_cnt);
        end else $display("drop_cnt_one ok");
      end
      bad = 1'b0;
      for (int k = 0; k < LANES; k++)
        if (dout_i[k] !== sample_t'(16*b+k) || dout_q[k] !== sample_t'(-(16*b+k))) bad = 1'b1;
      checks++;
      if (dout_valid !== 1'b1 || bad || dout_blk !== BLK_W'(b)) begin
        errors++;
        $display("FAIL drop_beat %0d: valid=%b blk=%0d i0=%0d, expected valid=1 blk=%0d i0=%0d",
                 b, dout_valid, dout_blk, dout_i[0], b, 16*b);
      end else $display("drop_beat %0d ok", b);
      @(negedge clk);
      frame_valid = 1'b0;
    end
    for (int n = 0; n < N_FFT; n++) begin
      frame_i[n] = sample_t'(n);
      frame_q[n] = sample_t'(-n);
    end
    dout_ready = 1'b0;
    load_frame();
    for (int p = 0; p < 300; p++) begin
      frame_valid = 1'b1;
      #1;
      if (p == 100) begin
        checks++;
        if (drop_cnt !== 8'd101) begin
          errors++;
          $display("FAIL drop_cnt_mid: got %0d expected 101", drop_cnt);
        end else $display("drop_cnt_mid ok");
      end
      @(negedge clk);
    end
    frame_valid = 1'b0;
    #1;
    checks++;
    if (drop_cnt !== 8'd255 || dout_valid !== 1'b1 || dout_blk !== 5'd0 || dout_i[1] !== 13'sd1) begin
      errors++;
      $display("FAIL drop_saturate: cnt=%0d valid=%b blk=%0d i1=%0d, expected cnt=255 valid=1 blk=0 i1=1",
               drop_cnt, dout_valid, dout_blk, dout_i[1]);
    end else $display("drop_saturate ok");
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b1;
    for (int c = 0; c < 40 && dout_blk != 5'd15; c++) @(negedge clk);
    #1;
    checks++;
    if (dout_blk !== 5'd15 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reach15: blk=%0d valid=%b expected blk=15 valid=1", dout_blk, dout_valid);
    end else $display("rstmid_reach15 ok");
    rst = 1'b1;
    #1;
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready_in_rst: got %b expected 0", frame_ready);
    end else $display("rstmid_ready_in_rst ok");
    @(negedge clk);
    #1;
    checks++;
    if (dout_valid !== 1'b0 || drop_cnt !== 8'd0 || frame_ready !== 1'b0 || dout_blk !== 5'd0) begin
      errors++;
      $display("FAIL rstmid_after: valid=%b drop=%0d ready=%b blk=%0d, expected 0 0 0 0",
               dout_valid, drop_cnt, frame_ready, dout_blk);
    end else $display("rstmid_after ok");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (frame_ready !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: ready=%b valid=%b expected ready=1 valid=0", frame_ready, dout_valid);
    end else $display("rstmid_release ok");
    for (int n = 0; n < N_FFT; n++) begin
      frame_i[n] = sample_t'(-n);
      frame_q[n] = sample_t'(n);
    end
    load_frame();
    #1;
    checks++;
    if (dout_valid !== 1'b1 || dout_blk !== 5'd0 || dout_i[2] !== -13'sd2 || dout_q[2] !== 13'sd2) begin
      errors++;
      $display("FAIL rstmid_newframe: valid=%b blk=%0d i2=%0d q2=%0d, expected 1 0 -2 2",
               dout_valid, dout_blk, dout_i[2], dout_q[2]);
    end else $display("rstmid_newframe ok");
    repeat (N_BLK) @(negedge clk);
  endtask

  task automatic test_extremes();
    bit bad;
    for (int n = 0; n < N_FFT; n++) begin
      frame_i[n] = (n % 2 == 0) ? sample_t'(-4096) : sample_t'(4095);
      frame_q[n] = (n % 2 == 0) ? sample_t'(4095)  : sample_t'(-4096);
    end
    dout_ready = 1'b1;
    load_frame();
    for (int b = 0; b < N_BLK; b++) begin
      #1;
      bad = 1'b0;
      for (int k = 0; k < LANES; k++) begin
        if (k % 2 == 0) begin
          if (dout_i[k] !== -13'sd4096 || dout_q[k] !== 13'sd4095) bad = 1'b1;
        end else begin
          if (dout_i[k] !== 13'sd4095 || dout_q[k] !== -13'sd4096) bad = 1'b1;
        end
      end
      checks++;
      if (dout_valid !== 1'b1 || bad || dout_blk !== BLK_W'(b)) begin
        errors++;
        $display("FAIL extreme_beat %0d: valid=%b blk=%0d i0=%0d i1=%0d, expected valid=1 blk=%0d i0=-4096 i1=4095",
                 b, dout_valid, dout_blk, dout_i[0], dout_i[1], b);
      end else $display("extreme_beat %0d ok", b);
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
